sdp_ram_streamer: RTL and testbench

Read-side companion to the AXI-written simple-dual-port RAM block. It drives the RAM's read-only port (addrb/dob) and converts a commanded run of consecutive RAM rows into an AXI4-Stream burst. Downstream backpressure is absorbed by a small credit-managed output FIFO, so RAM reads are never lost and never stall mid-pipeline.

---
 rtl/sdp_ram_pkg.sv | 31 +++
 rtl/stream_fifo.sv | 92 +++++++++
 rtl/sdp_ram_streamer.sv | 187 ++++++++++++++++++
 tb/tb_sdp_ram_streamer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// ============================================================================
// Module : sdp_ram_pkg
// Brief  : Shared constants, state encoding and sizing helpers for the
//          SDP RAM read streamer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sdp_ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_DRAIN = ST_DRAIN
    } state_e;

    // A depth of one row still needs a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
// Module : stream_fifo
// Brief  : Synchronous FIFO with a registered first-word output and an
//          occupancy count that includes the output register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stream_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int UW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [UW-1:0]    o_used
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [UW-1:0]    r_mcnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic w_pop;
    logic w_load;
    logic w_from_mem;
    logic w_bypass;
    logic w_mem_wr;

    // An empty FIFO forwards a push straight into the output register.
    assign w_pop      = r_valid & i_ready;
    assign w_load     = ~r_valid | w_pop;
    assign w_from_mem = w_load & (r_mcnt != '0);
    assign w_bypass   = w_load & (r_mcnt == '0) & i_push;
    assign w_mem_wr   = i_push & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mcnt   <= '0;
            r_valid  <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_from_mem) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_mcnt <= r_mcnt + UW'(w_mem_wr) - UW'(w_from_mem);
            if (w_load) begin
                r_valid <= w_from_mem | w_bypass;
                if (w_from_mem) begin
                    r_dout <= r_mem[r_rd_ptr];
                end else if (w_bypass) begin
                    r_dout <= i_data;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_dout;
    assign o_used  = r_mcnt + UW'(r_valid);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && (o_used == UW'(DEPTH)) && !w_pop));
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/sdp_ram_streamer.sv
// ============================================================================
// Module : sdp_ram_streamer
// Brief  : Streams a run of consecutive SDP RAM rows out as an AXI4-Stream
//          burst through a credit-managed output FIFO.
//          Optional: SDP_RAM_STREAMER_TUSER_EN adds M_AXIS_TUSER (row address).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdp_ram_streamer
    import sdp_ram_pkg::*;
#(
    parameter  int DW         = 512,
    parameter  int DD         = 16384,
    parameter  int RD_LATENCY = 1,
    parameter  int FIFO_DEPTH = 8,
    localparam int AW         = addr_width(DD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_count,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic [DW-1:0] M_AXIS_TDATA,
    output logic          M_AXIS_TVALID,
    output logic          M_AXIS_TLAST,
`ifdef SDP_RAM_STREAMER_TUSER_EN
    output logic [AW-1:0] M_AXIS_TUSER,
`endif
    input  logic          M_AXIS_TREADY,
    output logic          busy,
    output logic          done
);

    localparam int UW = $clog2(FIFO_DEPTH) + 1;
`ifdef SDP_RAM_STREAMER_TUSER_EN
    localparam int FW = DW + 1 + AW;
`else
    localparam int FW = DW + 1;
`endif
    localparam logic [UW:0]   C_DEPTH   = (UW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] C_ROW_MAX = AW'(DD - 1);
    localparam logic [AW:0]   C_ONE     = (AW + 1)'(1);

    logic [1:0]          r_state;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic [AW-1:0]       r_addrb;
    logic [AW-1:0]       r_row;
    logic [AW:0]         r_remain;
    logic [UW-1:0]       r_inflight;
    logic [RD_LATENCY:0] r_mk_v;
    logic [RD_LATENCY:0] r_mk_last;

    logic [1:0]    w_state_nxt;
    logic          w_accept;
    logic          w_start;
    logic          w_zero;
    logic          w_credit;
    logic          w_iss_run;
    logic          w_issue;
    logic [AW-1:0] w_iss_addr;
    logic          w_iss_last;
    logic [AW-1:0] w_next_row;
    logic          w_push;
    logic          w_pop;
    logic          w_finish;
    logic [FW-1:0] w_fifo_din;
    logic [FW-1:0] w_fifo_dout;
    logic          w_fifo_valid;
    logic [UW-1:0] w_used;

    assign w_accept   = cmd_valid & r_cmd_ready & (r_state == ST_IDLE);
    assign w_start    = w_accept & (cmd_count != '0);
    assign w_zero     = w_accept & (cmd_count == '0);
    // Entries already buffered plus reads still in the RAM pipe bound new issues.
    assign w_credit   = ({1'b0, w_used} + {1'b0, r_inflight}) < C_DEPTH;
    assign w_iss_run  = (r_state == ST_ISSUE) & (r_remain != '0) & w_credit;
    assign w_issue    = w_start | w_iss_run;
    assign w_iss_addr = w_start ? cmd_addr : r_row;
    assign w_iss_last = w_start ? (cmd_count == C_ONE) : (r_remain == C_ONE);
    assign w_next_row = (w_iss_addr == C_ROW_MAX) ? '0 : (w_iss_addr + AW'(1));
    assign w_push     = r_mk_v[RD_LATENCY];
    assign w_pop      = w_fifo_valid & M_AXIS_TREADY;
    assign w_finish   = (r_state == ST_DRAIN) & w_pop & w_fifo_dout[DW];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = w_iss_last ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: if (w_iss_run && w_iss_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_finish) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_zero | w_finish;
        end
    end

    // Stage 0 of the marker pipe lines up with the addrb register, so stage
    // RD_LATENCY marks the clock on which dob holds that row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addrb    <= '0;
            r_row      <= '0;
            r_remain   <= '0;
            r_inflight <= '0;
            r_mk_v     <= '0;
            r_mk_last  <= '0;
        end else begin
            if (w_issue) begin
                r_addrb <= w_iss_addr;
                r_row   <= w_next_row;
            end
            if (w_start) begin
                r_remain <= cmd_count - C_ONE;
            end else if (w_iss_run) begin
                r_remain <= r_remain - C_ONE;
            end
            r_inflight <= r_inflight + UW'(w_issue) - UW'(w_push);
            r_mk_v     <= {r_mk_v[RD_LATENCY-1:0], w_issue};
            r_mk_last  <= {r_mk_last[RD_LATENCY-1:0], w_issue & w_iss_last};
        end
    end

`ifdef SDP_RAM_STREAMER_TUSER_EN
    logic [AW-1:0] r_mk_addr [RD_LATENCY+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_mk_addr[i] <= '0;
            end
        end else begin
            r_mk_addr[0] <= w_iss_addr;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_mk_addr[i] <= r_mk_addr[i-1];
            end
        end
    end

    assign w_fifo_din   = {r_mk_addr[RD_LATENCY], r_mk_last[RD_LATENCY], dob};
    assign M_AXIS_TUSER = w_fifo_dout[DW+1 +: AW];
`else
    assign w_fifo_din   = {r_mk_last[RD_LATENCY], dob};
`endif

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .o_valid (w_fifo_valid),
        .i_ready (M_AXIS_TREADY),
        .o_data  (w_fifo_dout),
        .o_used  (w_used)
    );

    assign cmd_ready     = r_cmd_ready;
    assign addrb         = r_addrb;
    assign busy          = r_busy;
    assign done          = r_done;
    assign M_AXIS_TDATA  = w_fifo_dout[DW-1:0];
    assign M_AXIS_TLAST  = w_fifo_dout[DW];
    assign M_AXIS_TVALID = w_fifo_valid;

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_streamer.sv
// ============================================================================
// Module : tb_sdp_ram_streamer
// Brief  : Self-checking bench for sdp_ram_streamer with a latency-accurate
//          RAM read model and a beat scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sdp_ram_streamer;

    localparam int DW = 512;
    localparam int DD = 16384;
    localparam int RL = 2;
    localparam int FD = 8;
    localparam int AW = $clog2(DD);

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_count;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic          busy;
    logic          done;
`ifdef SDP_RAM_STREAMER_TUSER_EN
    logic [AW-1:0] M_AXIS_TUSER;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] user;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    sdp_ram_streamer #(
        .DW         (DW),
        .DD         (DD),
        .RD_LATENCY (RL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_addr      (cmd_addr),
        .cmd_count     (cmd_count),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .addrb         (addrb),
        .dob           (dob),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
`ifdef SDP_RAM_STREAMER_TUSER_EN
        .M_AXIS_TUSER  (M_AXIS_TUSER),
`endif
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [DW-1:0] row_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(i) << 20) ^ 32'h00C0FFEE;
        end
        return d;
    endfunction

    // RAM read port: dob shows the row addressed RL clocks earlier.
    logic [AW-1:0] ram_pipe [RL];
    always @(posedge clk) begin
        ram_pipe[0] <= addrb;
        for (int i = 1; i < RL; i++) begin
            ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign dob = row_data(ram_pipe[RL-1]);

    task automatic run_stream(input logic [AW-1:0] addr, input logic [AW:0] count,
                              input int mode, input int nruns, input string name);
        int    acc = 0, fin = 0, cyc = 0, acc_cyc = 0, tail = 0;
        bit    exp_done = 0, running = 0, lat_pending = 0, in_burst = 0;
        bit    pv = 0, pr = 0;
        logic [DW-1:0] pd = '0;
        logic  pl = 1'b0;
        beat_t b;
        @(negedge clk);
        cmd_addr  = addr;
        cmd_count = count;
        cmd_valid = 1'b1;
        while (tail < 4 && cyc < 2000) begin
            if (acc >= nruns) cmd_valid = 1'b0;
            M_AXIS_TREADY = (mode == 0) ? 1'b1 : ((cyc % 4) == 0);

            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL %s done: got %b want %b (cycle %0d)", name, done, exp_done, cyc);
            end
            if (done === 1'b1) begin
                fin++;
                running = 0;
            end
            exp_done = 0;

            n_cmp++;
            if (cmd_ready !== !running) begin
                n_err++;
                $display("FAIL %s cmd_ready: got %b want %b (cycle %0d)", name, cmd_ready, !running, cyc);
            end
            n_cmp++;
            if (busy !== running) begin
                n_err++;
                $display("FAIL %s busy: got %b want %b (cycle %0d)", name, busy, running, cyc);
            end

            n_cmp++;
            if (int'(dut.w_used) + int'(dut.r_inflight) > FD) begin
                n_err++;
                $display("FAIL %s credit: got %0d want <= %0d", name,
                         int'(dut.w_used) + int'(dut.r_inflight), FD);
            end

            if (pv && !pr) begin
                n_cmp++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== pd || M_AXIS_TLAST !== pl) begin
                    n_err++;
                    $display("FAIL %s stall_hold: got v=%b l=%b want v=1 l=%b (cycle %0d)",
                             name, M_AXIS_TVALID, M_AXIS_TLAST, pl, cyc);
                end
            end
            pv = M_AXIS_TVALID; pr = M_AXIS_TREADY; pd = M_AXIS_TDATA; pl = M_AXIS_TLAST;

            if (lat_pending && M_AXIS_TVALID === 1'b1) begin
                lat_pending = 0;
                n_cmp++;
                if (cyc - acc_cyc - 1 != RL + 1) begin
                    n_err++;
                    $display("FAIL %s latency: got %0d want %0d", name, cyc - acc_cyc - 1, RL + 1);
                end
            end

            if (mode == 0 && in_burst) begin
                n_cmp++;
                if (M_AXIS_TVALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s gap: got tvalid %b want 1 (cycle %0d)", name, M_AXIS_TVALID, cyc);
                end
            end

            if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_beat: got tdata %0h want no beat", name, M_AXIS_TDATA);
                end else begin
                    b = exp_q.pop_front();
                    if (M_AXIS_TDATA !== b.data || M_AXIS_TLAST !== b.last) begin
                        n_err++;
                        $display("FAIL %s beat: got last=%b data=%0h want last=%b data=%0h",
                                 name, M_AXIS_TLAST, M_AXIS_TDATA, b.last, b.data);
                    end
`ifdef SDP_RAM_STREAMER_TUSER_EN
                    n_cmp++;
                    if (M_AXIS_TUSER !== b.user) begin
                        n_err++;
                        $display("FAIL %s tuser: got %0d want %0d", name, M_AXIS_TUSER, b.user);
                    end
`endif
                    in_burst = !b.last;
                    if (b.last) exp_done = 1;
                end
            end

            if (cmd_valid && cmd_ready === 1'b1) begin
                acc++;
                acc_cyc = cyc;
                for (int i = 0; i < int'(count); i++) begin
                    b.user = AW'((int'(addr) + i) % DD);
                    b.data = row_data(b.user);
                    b.last = (i == int'(count) - 1);
                    exp_q.push_back(b);
                end
                if (count == '0) exp_done = 1;
                else begin
                    running = 1;
                    lat_pending = 1;
                end
            end

            if (fin >= nruns) tail++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 2000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s completion: got %0d beats left, cycle %0d want 0 left", name, exp_q.size(), cyc);
        end
        exp_q.delete();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0 || M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || addrb !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b v=%b l=%b busy=%b done=%b addrb=%0d want all 0",
                     cmd_ready, M_AXIS_TVALID, M_AXIS_TLAST, busy, done, addrb);
        end
`ifdef SDP_RAM_STREAMER_TUSER_EN
        n_cmp++;
        if (M_AXIS_TUSER !== '0) begin
            n_err++;
            $display("FAIL reset_tuser: got %0d want 0", M_AXIS_TUSER);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic;
        run_stream(AW'(10), (AW + 1)'(4), 0, 1, "basic");
    endtask

    task automatic test_wrap;
        run_stream(AW'(DD - 2), (AW + 1)'(4), 0, 1, "wrap");
        run_stream(AW'(DD - 1), (AW + 1)'(1), 1, 1, "wrap_single");
    endtask

    task automatic test_backpressure;
        run_stream(AW'(200), (AW + 1)'(20), 1, 1, "backpressure");
    endtask

    task automatic test_zero_count;
        run_stream(AW'(55), (AW + 1)'(0), 0, 1, "zero_count");
    endtask

    task automatic test_back_to_back;
        run_stream(AW'(100), (AW + 1)'(3), 0, 2, "back_to_back");
    endtask

    task automatic test_reset_mid_run;
        int guard = 0;
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        cmd_addr  = AW'(300);
        cmd_count = (AW + 1)'(20);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (int'(dut.w_used) != 3 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50 || M_AXIS_TVALID !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_fill: got used=%0d tvalid=%b want used=3 tvalid=1",
                     dut.w_used, M_AXIS_TVALID);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            dut.w_used !== '0 || dut.r_inflight !== '0 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: got v=%b busy=%b done=%b used=%0d infl=%0d rdy=%b want 0s",
                     M_AXIS_TVALID, busy, done, dut.w_used, dut.r_inflight, cmd_ready);
        end
        run_stream(AW'(40), (AW + 1)'(2), 0, 1, "after_reset");
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_count     = '0;
        M_AXIS_TREADY = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
